// File: rtl/fetch_decode_queue_if.sv
// rtl/fetch_decode_queue_if.sv - fetch-side and decode-side handshake bundle for the instruction queue
interface fetch_decode_queue_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int XLEN        = 32
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(ISSUE_WIDTH + 1);

    logic                        flush;
    logic [FETCH_WIDTH-1:0]      in_valid;
    logic [FETCH_WIDTH*XLEN-1:0] in_instr;
    logic [FETCH_WIDTH*XLEN-1:0] in_pc;
    logic [FETCH_WIDTH-1:0]      in_is_branch;
    logic [FETCH_WIDTH-1:0]      in_pred_taken;
    logic                        in_ready;
    logic [ISSUE_WIDTH-1:0]      out_valid;
    logic [ISSUE_WIDTH*XLEN-1:0] out_instr;
    logic [ISSUE_WIDTH*XLEN-1:0] out_pc;
    logic [ISSUE_WIDTH-1:0]      out_pred_taken;
    logic [DW-1:0]               deq_count;
    logic [CW-1:0]               occupancy;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_is_branch, in_pred_taken, deq_count,
        output in_ready, out_valid, out_instr, out_pc, out_pred_taken, occupancy
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, in_is_branch, in_pred_taken, deq_count,
        input  in_ready, out_valid, out_instr, out_pc, out_pred_taken, occupancy
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - circular fetch/decode queue with taken-branch truncation and compaction
module fetch_decode_queue #(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int XLEN        = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    fetch_decode_queue_if.slave   q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]        mem_instr [DEPTH];
    logic [XLEN-1:0]        mem_pc    [DEPTH];
    logic [DEPTH-1:0]       mem_pt;

    logic [PW-1:0]          head;
    logic [PW-1:0]          tail;
    logic [CW-1:0]          count;

    logic [FETCH_WIDTH-1:0] keep;
    logic [FETCH_WIDTH-1:0] keep_pt;
    logic [PW-1:0]          slot_off [FETCH_WIDTH];
    logic                   killed;
    logic [CW-1:0]          enq_cnt;
    logic [CW-1:0]          deq_req;
    logic [CW-1:0]          deq_cnt;
    logic [CW-1:0]          count_next;
    logic                   in_ready_c;
    logic                   accept;
    logic [PW-1:0]          rd_idx [ISSUE_WIDTH];

    // Survivors stop at the first predicted-taken branch; each keeps its
    // compacted offset from tail so invalid gaps never occupy storage.
    always_comb begin
        killed  = 1'b0;
        enq_cnt = '0;
        keep    = '0;
        keep_pt = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_off[i] = enq_cnt[PW-1:0];
            keep[i]     = q.in_valid[i] && !killed;
            keep_pt[i]  = q.in_is_branch[i] && q.in_pred_taken[i];
            if (keep[i]) begin
                enq_cnt = enq_cnt + 1'b1;
                if (keep_pt[i]) begin
                    killed = 1'b1;
                end
            end
        end
    end

    // Readiness looks only at registered occupancy so fetch never sees a
    // path through decode's same-cycle consumption.
    always_comb begin
        in_ready_c = ((CW'(DEPTH) - count) >= CW'(FETCH_WIDTH)) && !q.flush;
        accept     = in_ready_c && (|keep);
        deq_req    = CW'(q.deq_count);
        deq_cnt    = (deq_req > count) ? count : deq_req;
        count_next = count - deq_cnt + (accept ? enq_cnt : '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            mem_pt <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                mem_instr[j] <= '0;
                mem_pc[j]    <= '0;
            end
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_cnt[PW-1:0];
            count <= count_next;
            if (accept) begin
                tail <= tail + enq_cnt[PW-1:0];
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (keep[i]) begin
                        mem_instr[tail + slot_off[i]] <= q.in_instr[i*XLEN +: XLEN];
                        mem_pc[tail + slot_off[i]]    <= q.in_pc[i*XLEN +: XLEN];
                        mem_pt[tail + slot_off[i]]    <= keep_pt[i];
                    end
                end
            end
        end
    end

    // Head window is a direct read of storage; empty slots are forced to zero.
    always_comb begin
        q.out_valid      = '0;
        q.out_instr      = '0;
        q.out_pc         = '0;
        q.out_pred_taken = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            rd_idx[i] = head + PW'(i);
            if (count > CW'(i)) begin
                q.out_valid[i]               = 1'b1;
                q.out_instr[i*XLEN +: XLEN]  = mem_instr[rd_idx[i]];
                q.out_pc[i*XLEN +: XLEN]     = mem_pc[rd_idx[i]];
                q.out_pred_taken[i]          = mem_pt[rd_idx[i]];
            end
        end
    end

    assign q.in_ready  = in_ready_c;
    assign q.occupancy = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - randomized and directed bench for fetch_decode_queue against a queue model
module tb_fetch_decode_queue;
    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pt;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    fetch_decode_queue_if #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    fetch_decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .q    (bus)
    );

    ent_t        mq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] next_pc  = 32'h100;
    logic [31:0] exp_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [IW-1:0]      ev;
        logic [IW-1:0]      ept;
        logic [IW*XLEN-1:0] epc;
        logic [IW*XLEN-1:0] ein;
        ev  = '0;
        ept = '0;
        epc = '0;
        ein = '0;
        for (int i = 0; i < IW; i++) begin
            if (i < mq.size()) begin
                ev[i]              = 1'b1;
                ept[i]             = mq[i].pt;
                epc[i*XLEN +: XLEN] = mq[i].pc;
                ein[i*XLEN +: XLEN] = mq[i].instr;
            end
        end
        check("out_valid", 64'(bus.out_valid), 64'(ev));
        check("out_pc", 64'(bus.out_pc), 64'(epc));
        check("out_instr", 64'(bus.out_instr), 64'(ein));
        check("out_pred_taken", 64'(bus.out_pred_taken), 64'(ept));
        check("occupancy", 64'(bus.occupancy), 64'(mq.size()));
    endtask

    task automatic set_in(input logic [FW-1:0] v, input logic [FW-1:0] br,
                          input logic [FW-1:0] pt, input int d, input logic fl);
        bus.in_valid      = v;
        bus.in_is_branch  = br;
        bus.in_pred_taken = pt;
        for (int i = 0; i < FW; i++) begin
            bus.in_pc[i*XLEN +: XLEN]    = next_pc + 32'(4 * i);
            bus.in_instr[i*XLEN +: XLEN] = $urandom;
        end
        next_pc       = next_pc + 32'(4 * FW);
        bus.deq_count = 2'(d);
        bus.flush     = fl;
    endtask

    // Called at posedge+1 with inputs already driven; advances the model by one edge.
    task automatic cycle();
        bit   rdy;
        int   d;
        ent_t e;
        #1;
        rdy = ((DEPTH - mq.size()) >= FW) && !bus.flush;
        check("in_ready", 64'(bus.in_ready), 64'(rdy));
        if (bus.flush) begin
            mq.delete();
        end else begin
            d = int'(bus.deq_count);
            if (d > mq.size()) d = mq.size();
            repeat (d) void'(mq.pop_front());
            if (rdy) begin
                for (int i = 0; i < FW; i++) begin
                    if (bus.in_valid[i]) begin
                        e.pc    = bus.in_pc[i*XLEN +: XLEN];
                        e.instr = bus.in_instr[i*XLEN +: XLEN];
                        e.pt    = bus.in_is_branch[i] && bus.in_pred_taken[i];
                        mq.push_back(e);
                        if (e.pt) break;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic random_cycles(input int n);
        logic [FW-1:0] v, br, pt;
        for (int c = 0; c < n; c++) begin
            v  = FW'($urandom);
            br = FW'($urandom);
            pt = FW'($urandom) & FW'($urandom);
            set_in(v, br, pt, $urandom_range(0, 2), $urandom_range(0, 19) == 0);
            cycle();
        end
    endtask

    initial begin
        set_in('0, '0, '0, 0, 1'b0);
        next_pc = 32'h100;
        #12;
        check("rst_occupancy", 64'(bus.occupancy), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // basic flow
        set_in(2'b11, 2'b00, 2'b00, 0, 1'b0);
        cycle();
        check("basic_pc", 64'(bus.out_pc), {32'h104, 32'h100});
        check("basic_occ", 64'(bus.occupancy), 64'd2);
        set_in('0, '0, '0, 2, 1'b0);
        cycle();
        check("basic_drain", 64'(bus.occupancy), 64'd0);

        // predicted-taken truncation and gap compaction
        set_in(2'b11, 2'b01, 2'b01, 0, 1'b0);
        cycle();
        check("trunc_occ", 64'(bus.occupancy), 64'd1);
        check("trunc_pt", 64'(bus.out_pred_taken[0]), 64'd1);
        set_in('0, '0, '0, 1, 1'b0);
        cycle();
        exp_pc = next_pc + 32'd4;
        set_in(2'b10, 2'b00, 2'b00, 0, 1'b0);
        cycle();
        check("gap_pc", 64'(bus.out_pc[31:0]), 64'(exp_pc));
        set_in('0, '0, '0, 2, 1'b0);
        cycle();

        // full, ignored fifth group, then drain across the wrap
        repeat (4) begin
            set_in(2'b11, 2'b00, 2'b00, 0, 1'b0);
            cycle();
        end
        check("full_occ", 64'(bus.occupancy), 64'd8);
        check("full_ready", 64'(bus.in_ready), 64'd0);
        set_in(2'b11, 2'b00, 2'b00, 0, 1'b0);
        cycle();
        check("full_ignored", 64'(bus.occupancy), 64'd8);
        repeat (6) begin
            set_in(2'b11, 2'b00, 2'b00, 2, 1'b0);
            cycle();
        end
        repeat (5) begin
            set_in('0, '0, '0, 2, 1'b0);
            cycle();
        end

        // flush with simultaneous enqueue and dequeue
        set_in(2'b11, 2'b00, 2'b00, 0, 1'b0);
        cycle();
        set_in(2'b11, 2'b00, 2'b00, 0, 1'b0);
        cycle();
        set_in(2'b01, 2'b00, 2'b00, 0, 1'b0);
        cycle();
        check("pre_flush_occ", 64'(bus.occupancy), 64'd5);
        set_in(2'b11, 2'b00, 2'b00, 2, 1'b1);
        cycle();
        check("flush_occ", 64'(bus.occupancy), 64'd0);
        check("flush_valid", 64'(bus.out_valid), 64'd0);
        set_in('0, '0, '0, 0, 1'b0);
        #1;
        check("flush_ready", 64'(bus.in_ready), 64'd1);
        cycle();

        random_cycles(400);

        // async reset mid-stream
        repeat (5) begin
            set_in('0, '0, '0, 2, 1'b0);
            cycle();
        end
        repeat (3) begin
            set_in(2'b11, 2'b00, 2'b00, 0, 1'b0);
            cycle();
        end
        check("pre_reset_occ", 64'(bus.occupancy), 64'd6);
        set_in('0, '0, '0, 0, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_occ", 64'(bus.occupancy), 64'd0);
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_pc", 64'(bus.out_pc), 64'd0);
        check("arst_ready", 64'(bus.in_ready), 64'd1);
        mq.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        random_cycles(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
Parametrised successor to the dual-issue fetch/decode pipeline register. It is a circular instruction queue between fetch and decode. It accepts up to FETCH_WIDTH instructions per cycle, kills slots younger than a predicted-taken branch, compacts the survivors, and presents up to ISSUE_WIDTH oldest entries to decode. Decode stalls are absorbed by buffering, not by holding the fetch register.

Parameters:
FETCH_WIDTH, 2, instructions offered by fetch per cycle (>=1)
ISSUE_WIDTH, 2, instruction slots presented to decode per cycle (>=1)
DEPTH, 8, queue entries; power of 2, >= FETCH_WIDTH+ISSUE_WIDTH
XLEN, 32, instruction and PC width
CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)
DW, $clog2(ISSUE_WIDTH+1), dequeue count width (derived)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset
flush  in  1  synchronous flush (branch mispredict / redirect)
in_valid  in  FETCH_WIDTH  per-slot fetch valid; slot 0 is oldest
in_instr  in  FETCH_WIDTH*XLEN  packed instructions; slot i at [i*XLEN +: XLEN]
in_pc  in  FETCH_WIDTH*XLEN  packed PCs
in_is_branch  in  FETCH_WIDTH  slot holds a branch/jump
in_pred_taken  in  FETCH_WIDTH  predictor says taken
in_ready  out  1  queue accepts a fetch group this cycle
out_valid  out  ISSUE_WIDTH  head slot i valid; thermometer coded
out_instr  out  ISSUE_WIDTH*XLEN  head instructions, oldest in slot 0
out_pc  out  ISSUE_WIDTH*XLEN  head PCs
out_pred_taken  out  ISSUE_WIDTH  predict state carried with each instruction
deq_count  in  DW  entries consumed by decode this cycle
occupancy  out  CW  current entry count

Behaviour:
- Reset:
  - rstn is asynchronous, active-low; clock is clk.
  - On reset: head=0, tail=0, count=0, storage cleared to 0, in_ready=1, out_valid=0, out_instr/out_pc/out_pred_taken=0, occupancy=0.
- Enqueue:
  - in_ready = (DEPTH - count >= FETCH_WIDTH) && !flush. It depends only on registered count and flush, never on the same-cycle deq_count.
  - A group is accepted on a rising edge when in_ready=1 and at least one slot is valid after truncation. If in_ready=0, the group is ignored; fetch must hold it.
- Truncation:
  - Let k be the lowest slot with in_valid && in_is_branch && in_pred_taken.
  - Slots above k are killed. Slot k itself is kept, with pred_taken=1.
  - in_pred_taken on non-branch slots is stored as 0.
- Compaction:
  - Surviving valid slots are written in slot order to tail, tail+1, ... (mod DEPTH).
  - Invalid gaps are skipped; tail advances by the survivor count.
- Dequeue:
  - out_valid[i] = (count > i). Head fields are a combinational read of storage at head+i (mod DEPTH); they are 0 when out_valid[i]=0.
  - Zero-latency read: an entry written at edge N is visible on the outputs after edge N.
  - On each edge, head advances by min(deq_count, count) and those entries leave. deq_count > count is clamped.
  - A stall is deq_count=0: the queue holds its contents.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count_next = count - deq + enq.
  - Full queue plus dequeue: in_ready stays 0 this cycle (no bypass) and rises next cycle.
- Flush:
  - Highest priority. On the edge where flush=1: count=0, head=tail=0, and any same-cycle enqueue and dequeue are discarded.
  - Outputs show out_valid=0 from the next cycle. Storage need not be cleared.
- Wrap-around:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - A group may straddle the end of storage; entries stay contiguous modulo DEPTH.
- Arithmetic: count is CW bits and never exceeds DEPTH. Survivor count is the popcount of the post-truncation valid vector.
- Reset mid-operation: async reset clears all state immediately, whatever flush or handshake is in progress.

Test Plan:
- Reset then idle:
  - Stimulus: deassert rstn, no input.
  - Required: occupancy=0, out_valid=00, in_ready=1.
- Basic flow:
  - Stimulus: group {pc 0x100 instr A, pc 0x104 instr B}, deq_count=0.
  - Required: next cycle out_valid=11, out_pc={0x104,0x100}, occupancy=2. With deq_count=2 the cycle after, occupancy=0.
- Predicted-taken truncation:
  - Stimulus: slot0 is a branch with pred_taken=1, slot1 valid.
  - Required: only slot0 enqueued (occupancy 1), out_pred_taken[0]=1, slot1 never appears.
  - Also: in_valid=10 (slot0 invalid) enqueues slot1 into head slot0.
- Full and wrap:
  - Stimulus: DEPTH=8, four groups with deq_count=0.
  - Required: occupancy=8, in_ready=0, a fifth group is ignored.
  - Then deq_count=2 for 6 cycles while enqueuing 2 per cycle once ready: PCs leave in strict order across the wrap, with no duplicates or losses.
- Flush with simultaneous traffic:
  - Stimulus: occupancy 5, then flush=1 together with a valid group and deq_count=2.
  - Required: next cycle occupancy=0, out_valid=00, the group is not stored, in_ready=1.
- Async reset mid-stream:
  - Stimulus: assert rstn low between clock edges with occupancy 6.
  - Required: outputs go to 0 immediately, with no clock needed.
